// File: rtl/store_buffer.sv
// Posted-write buffer in front of the data memory. Queues word stores in a
// DEPTH-entry FIFO, drains one per cycle to dm, and forwards buffered data to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_pc,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  input  logic                     drain_en,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  output logic                     MemWrite,
  output logic [31:0]              pc,
  output logic [AW-1:0]            addr,
  output logic [31:0]              din,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]   pc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [DEPTH-1:0] match;

  assign st_ready = (count != CW'(DEPTH));
  assign push     = st_valid && st_ready;
  assign pop      = drain_en && (count != '0);
  assign empty    = (count == '0) && !MemWrite;

  // Entry payload needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: st_pc, addr: st_addr, data: st_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      MemWrite <= 1'b0;
      pc       <= '0;
      addr     <= '0;
      din      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        MemWrite <= 1'b1;
        pc       <= mem[rd_ptr].pc;
        addr     <= mem[rd_ptr].addr;
        din      <= mem[rd_ptr].data;
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        MemWrite <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // match[g]: the g-th oldest live entry holds ld_addr
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_match
      assign match[g] = (CW'(g) < count) && (mem[rd_ptr + PW'(g)].addr == ld_addr);
    end
  endgenerate

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    if (MemWrite && addr == ld_addr) begin
      ld_hit  = 1'b1;
      ld_data = din;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) begin
        ld_hit  = 1'b1;
        ld_data = mem[rd_ptr + PW'(i)].data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clk, reset;
  logic          st_valid, st_ready;
  logic [31:0]   st_pc, st_data;
  logic [AW-1:0] st_addr, ld_addr;
  logic          drain_en, ld_hit, MemWrite, empty;
  logic [31:0]   ld_data, pc, din;
  logic [AW-1:0] addr;
  logic [2:0]    count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_pc(st_pc), .st_addr(st_addr), .st_data(st_data), .drain_en(drain_en),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .MemWrite(MemWrite),
    .pc(pc), .addr(addr), .din(din), .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending stores plus the output stage.
  typedef struct {
    logic [31:0]   pc;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } st_t;
  st_t           mq[$];
  logic          m_mw = 0;
  logic [31:0]   m_pc = 0, m_din = 0;
  logic [AW-1:0] m_addr = 0;
  int            n_acc = 0;

  // dm stand-in: records every committed write
  logic [31:0] dm [int];
  int          nwr = 0;

  always @(posedge clk) begin
    if (MemWrite === 1'b1) begin
      dm[int'(addr)] = din;
      nwr++;
    end
  end

  always @(posedge clk) begin
    int  n;
    st_t e;
    if (reset === 1'b0) begin
      mq.delete();
      m_mw = 0; m_pc = 0; m_addr = 0; m_din = 0;
    end else begin
      n = mq.size();
      if (drain_en && n > 0) begin
        e = mq.pop_front();
        m_mw = 1; m_pc = e.pc; m_addr = e.a; m_din = e.d;
      end else begin
        m_mw = 0;
      end
      if (st_valid && n < DEPTH) begin
        e.pc = st_pc; e.a = st_addr; e.d = st_data;
        mq.push_back(e);
        n_acc++;
      end
    end
  end

  function automatic void fwd(output logic h, output logic [31:0] d);
    h = 0; d = 0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == ld_addr) begin
        h = 1; d = mq[i].d;
        return;
      end
    end
    if (m_mw && m_addr == ld_addr) begin
      h = 1; d = m_din;
    end
  endfunction

  always @(negedge clk) begin
    logic        eh;
    logic [31:0] ed;
    if (chk_on) begin
      chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0 && !m_mw));
      chk("MemWrite", 32'(MemWrite), 32'(m_mw));
      if (m_mw) begin
        chk("addr", 32'(addr), 32'(m_addr));
        chk("din", din, m_din);
        chk("pc", pc, m_pc);
      end
      fwd(eh, ed);
      chk("ld_hit", 32'(ld_hit), 32'(eh));
      chk("ld_data", ld_data, ed);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] p);
    st_valid = 1; st_addr = a; st_data = d; st_pc = p;
  endtask

  initial begin
    int w0, a0;
    reset = 0; st_valid = 0; st_pc = 0; st_addr = 0; st_data = 0;
    drain_en = 0; ld_addr = 0;

    // 1: reset
    repeat (2) tick();
    chk_on = 1;
    reset = 1;
    tick();
    chk("t1 MemWrite", 32'(MemWrite), 0);
    chk("t1 count", 32'(count), 0);
    chk("t1 empty", 32'(empty), 1);
    chk("t1 st_ready", 32'(st_ready), 1);
    chk("t1 ld_hit", 32'(ld_hit), 0);

    // 2: single store latency
    drain_en = 1;
    push_set(10'h004, 32'hDEADBEEF, 32'h3000);
    tick();
    st_valid = 0;
    chk("t2 count e1", 32'(count), 1);
    chk("t2 MemWrite e1", 32'(MemWrite), 0);
    tick();
    chk("t2 MemWrite e2", 32'(MemWrite), 1);
    chk("t2 addr", 32'(addr), 32'h004);
    chk("t2 din", din, 32'hDEADBEEF);
    chk("t2 pc", pc, 32'h3000);
    tick();
    chk("t2 MemWrite e3", 32'(MemWrite), 0);
    chk("t2 dm[4]", dm.exists(4) ? dm[4] : 32'h0, 32'hDEADBEEF);

    // 3: fill, reject 5th, drain in order
    drain_en = 0;
    for (int i = 1; i <= 4; i++) begin
      push_set(AW'(i), 32'h100 + i, 32'h4000 + 4 * i);
      tick();
    end
    chk("t3 count", 32'(count), 4);
    chk("t3 st_ready", 32'(st_ready), 0);
    push_set(10'h005, 32'h105, 32'h4014);
    tick();
    chk("t3 count after 5th", 32'(count), 4);
    st_valid = 0;
    drain_en = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3 MemWrite", 32'(MemWrite), 1);
      chk("t3 addr order", 32'(addr), i);
    end
    tick();
    chk("t3 MemWrite done", 32'(MemWrite), 0);

    // 4: forwarding youngest
    drain_en = 0;
    push_set(10'h010, 32'h11, 32'h5000); tick();
    push_set(10'h010, 32'h22, 32'h5004); tick();
    st_valid = 0;
    ld_addr = 10'h010; #1;
    chk("t4 ld_hit", 32'(ld_hit), 1);
    chk("t4 ld_data", ld_data, 32'h22);
    ld_addr = 10'h011; #1;
    chk("t4 miss hit", 32'(ld_hit), 0);
    chk("t4 miss data", ld_data, 0);
    drain_en = 1;
    repeat (4) tick();

    // 5: full buffer, continuous push and drain, pointer wrap
    w0 = nwr; a0 = n_acc;
    drain_en = 0;
    for (int i = 0; i < 4; i++) begin
      push_set(AW'(32'h20 + i), 32'hA000 + i, 32'h6000 + 4 * i);
      tick();
    end
    drain_en = 1;
    for (int i = 0; i < 12; i++) begin
      push_set(AW'(32'h30 + i), 32'hB000 + i, 32'h7000 + 4 * i);
      tick();
    end
    st_valid = 0;
    repeat (10) tick();
    chk("t5 writes==accepts", 32'(nwr - w0), 32'(n_acc - a0));
    chk("t5 drained", 32'(empty), 1);

    // 6: reset mid-drain
    drain_en = 0;
    for (int i = 0; i < 3; i++) begin
      push_set(AW'(32'h40 + i), 32'hC000 + i, 32'h8000 + 4 * i);
      tick();
    end
    st_valid = 0;
    drain_en = 1;
    tick();
    chk("t6 draining", 32'(MemWrite), 1);
    reset = 0;
    tick();
    chk("t6 MemWrite", 32'(MemWrite), 0);
    chk("t6 count", 32'(count), 0);
    reset = 1;
    w0 = nwr;
    repeat (6) tick();
    chk("t6 no late writes", 32'(nwr - w0), 0);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      reset    = ($urandom_range(0, 149) != 0);
      drain_en = ($urandom_range(0, 2) != 0);
      st_valid = $urandom_range(0, 1);
      st_addr  = AW'($urandom_range(0, 7));
      st_data  = $urandom;
      st_pc    = $urandom;
      ld_addr  = AW'($urandom_range(0, 7));
      tick();
    end
    reset = 1; st_valid = 0; drain_en = 1;
    repeat (8) tick();
    chk("final empty", 32'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
